// File: rtl/register_file_mp.sv
// register_file_mp: multi-port flop register file with registered reads,
// optional hardwired-zero register 0 and optional write-to-read bypass.
module register_file_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic [NUM_RD-1:0]       rd_en,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0]        regs   [DEPTH];
    logic [WIDTH-1:0]        regs_d [DEPTH];
    logic [NUM_RD*WIDTH-1:0] rd_q, rd_d;
    // Ports are applied in ascending order so the highest-index writer wins.
    always_comb begin
        regs_d = regs;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && int'(wr_addr[i*AW +: AW]) < DEPTH &&
                !(ZERO_REG != 0 && wr_addr[i*AW +: AW] == '0))
                regs_d[wr_addr[i*AW +: AW]] = wr_data[i*WIDTH +: WIDTH];
        end
    end
    // Bypass reads the post-write array, so it matches the value held after the edge.
    always_comb begin
        rd_d = rd_q;
        for (int j = 0; j < NUM_RD; j++) begin
            if (rd_en[j])
                rd_d[j*WIDTH +: WIDTH] = int'(rd_addr[j*AW +: AW]) >= DEPTH ? '0 :
                    BYPASS != 0 ? regs_d[rd_addr[j*AW +: AW]] : regs[rd_addr[j*AW +: AW]];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
            rd_q <= '0;
        end else begin
            regs <= regs_d;
            rd_q <= rd_d;
        end
    end
    assign rd_data = rd_q;
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: two builds driven in lockstep -- A (zero reg, bypass)
// and B (no zero reg, no bypass), both DEPTH=24 with 2 write and 3 read ports.
module tb_register_file_mp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [2:0]  rd_en = '0;
    logic [14:0] rd_addr = '0;
    logic [95:0] rd_data_a, rd_data_b;
    int total = 0;
    int bad = 0;

    register_file_mp #(.WIDTH(32), .DEPTH(24), .NUM_RD(3), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a));
    register_file_mp #(.WIDTH(32), .DEPTH(24), .NUM_RD(3), .NUM_WR(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0;
        rd_en = '0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*5 +: 5] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_en[p] = 1'b1;
        rd_addr[p*5 +: 5] = a;
    endtask

    task automatic test_reset();
        #3;
        total += 2;
        if (rd_data_a !== '0) begin bad++; $display("FAIL reset_a got=%h exp=0", rd_data_a); end
        if (rd_data_b !== '0) begin bad++; $display("FAIL reset_b got=%h exp=0", rd_data_b); end
        rst_n = 1'b1;
        tick();
        wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle(); rd(0, 5'd5);
        tick();
        idle();
        total += 1;
        if (rd_data_a[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_reset_read got=%h exp=deadbeef", rd_data_a[31:0]); end
        #2 rst_n = 1'b0;
        #1;
        total += 2;
        if (rd_data_a !== '0) begin bad++; $display("FAIL async_clear_a got=%h exp=0", rd_data_a); end
        if (rd_data_b !== '0) begin bad++; $display("FAIL async_clear_b got=%h exp=0", rd_data_b); end
        rst_n = 1'b1;
        tick();
        rd(0, 5'd5);
        tick();
        idle();
        total += 2;
        if (rd_data_a[31:0] !== '0) begin bad++; $display("FAIL reg5_after_reset_a got=%h exp=0", rd_data_a[31:0]); end
        if (rd_data_b[31:0] !== '0) begin bad++; $display("FAIL reg5_after_reset_b got=%h exp=0", rd_data_b[31:0]); end
        rst_n = 1'b0;
        wr(0, 5'd6, 32'hCAFE0006);
        tick();
        idle();
        rst_n = 1'b1;
        tick();
        rd(1, 5'd6);
        tick();
        idle();
        total += 2;
        if (rd_data_a[63:32] !== '0) begin bad++; $display("FAIL write_in_reset_a got=%h exp=0", rd_data_a[63:32]); end
        if (rd_data_b[63:32] !== '0) begin bad++; $display("FAIL write_in_reset_b got=%h exp=0", rd_data_b[63:32]); end
    endtask

    task automatic test_zero();
        wr(0, 5'd0, 32'hFFFFFFFF);
        tick();
        idle(); rd(0, 5'd0);
        tick();
        idle();
        total += 2;
        if (rd_data_a[31:0] !== '0) begin bad++; $display("FAIL zero_a got=%h exp=0", rd_data_a[31:0]); end
        if (rd_data_b[31:0] !== 32'hFFFFFFFF) begin bad++; $display("FAIL zero_b got=%h exp=ffffffff", rd_data_b[31:0]); end
        wr(1, 5'd0, 32'h00001234); rd(1, 5'd0);
        tick();
        idle();
        total += 2;
        if (rd_data_a[63:32] !== '0) begin bad++; $display("FAIL zero_bypass_a got=%h exp=0", rd_data_a[63:32]); end
        if (rd_data_b[63:32] !== 32'hFFFFFFFF) begin bad++; $display("FAIL zero_old_b got=%h exp=ffffffff", rd_data_b[63:32]); end
    endtask

    task automatic test_bypass();
        wr(0, 5'd7, 32'h11);
        tick();
        idle(); wr(0, 5'd7, 32'h22); rd(2, 5'd7);
        tick();
        idle();
        total += 2;
        if (rd_data_a[95:64] !== 32'h22) begin bad++; $display("FAIL bypass_a got=%h exp=22", rd_data_a[95:64]); end
        if (rd_data_b[95:64] !== 32'h11) begin bad++; $display("FAIL bypass_b got=%h exp=11", rd_data_b[95:64]); end
        rd(2, 5'd7);
        tick();
        idle();
        total += 2;
        if (rd_data_a[95:64] !== 32'h22) begin bad++; $display("FAIL bypass_next_a got=%h exp=22", rd_data_a[95:64]); end
        if (rd_data_b[95:64] !== 32'h22) begin bad++; $display("FAIL bypass_next_b got=%h exp=22", rd_data_b[95:64]); end
    endtask

    task automatic test_conflict();
        wr(0, 5'd3, 32'hAAAA); wr(1, 5'd3, 32'h5555); rd(0, 5'd3);
        tick();
        idle();
        total += 2;
        if (rd_data_a[31:0] !== 32'h5555) begin bad++; $display("FAIL conflict_bypass_a got=%h exp=5555", rd_data_a[31:0]); end
        if (rd_data_b[31:0] !== 32'h0) begin bad++; $display("FAIL conflict_old_b got=%h exp=0", rd_data_b[31:0]); end
        rd(0, 5'd3);
        tick();
        idle();
        total += 2;
        if (rd_data_a[31:0] !== 32'h5555) begin bad++; $display("FAIL conflict_a got=%h exp=5555", rd_data_a[31:0]); end
        if (rd_data_b[31:0] !== 32'h5555) begin bad++; $display("FAIL conflict_b got=%h exp=5555", rd_data_b[31:0]); end
    endtask

    task automatic test_hold();
        wr(0, 5'd9, 32'h1234); wr(1, 5'd10, 32'h77);
        tick();
        idle(); rd(0, 5'd9); rd(1, 5'd9); rd(2, 5'd9);
        tick();
        idle();
        total += 2;
        if (rd_data_a !== {3{32'h1234}}) begin bad++; $display("FAIL same_addr_a got=%h exp=%h", rd_data_a, {3{32'h1234}}); end
        if (rd_data_b !== {3{32'h1234}}) begin bad++; $display("FAIL same_addr_b got=%h exp=%h", rd_data_b, {3{32'h1234}}); end
        rd_addr = {5'd10, 5'd10, 5'd10};
        rd_en = 3'b010;
        tick();
        idle();
        total += 2;
        if (rd_data_a !== {32'h1234, 32'h77, 32'h1234}) begin bad++; $display("FAIL hold_a got=%h", rd_data_a); end
        if (rd_data_b !== {32'h1234, 32'h77, 32'h1234}) begin bad++; $display("FAIL hold_b got=%h", rd_data_b); end
    endtask

    task automatic test_range();
        wr(0, 5'd25, 32'h0BAD); wr(1, 5'd23, 32'h2323); rd(0, 5'd25); rd(1, 5'd23);
        tick();
        idle();
        total += 4;
        if (rd_data_a[31:0] !== '0) begin bad++; $display("FAIL oor_read_a got=%h exp=0", rd_data_a[31:0]); end
        if (rd_data_b[31:0] !== '0) begin bad++; $display("FAIL oor_read_b got=%h exp=0", rd_data_b[31:0]); end
        if (rd_data_a[63:32] !== 32'h2323) begin bad++; $display("FAIL last_bypass_a got=%h exp=2323", rd_data_a[63:32]); end
        if (rd_data_b[63:32] !== '0) begin bad++; $display("FAIL last_old_b got=%h exp=0", rd_data_b[63:32]); end
        rd(2, 5'd23);
        tick();
        idle();
        total += 2;
        if (rd_data_a[95:64] !== 32'h2323) begin bad++; $display("FAIL last_a got=%h exp=2323", rd_data_a[95:64]); end
        if (rd_data_b[95:64] !== 32'h2323) begin bad++; $display("FAIL last_b got=%h exp=2323", rd_data_b[95:64]); end
    endtask

    task automatic test_random();
        logic [31:0] m [2][24];
        logic [31:0] nm [2][24];
        logic [95:0] e [2];
        int a;
        idle();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            e[d] = '0;
            for (int r = 0; r < 24; r++) m[d][r] = '0;
        end
        for (int c = 0; c < 10000; c++) begin
            wr_en = 2'($urandom);
            wr_addr = 10'($urandom);
            wr_data = {$urandom, $urandom};
            rd_en = 3'($urandom);
            rd_addr = 15'($urandom);
            for (int d = 0; d < 2; d++) begin
                nm[d] = m[d];
                for (int p = 0; p < 2; p++) begin
                    a = int'(wr_addr[p*5 +: 5]);
                    if (wr_en[p] && a < 24 && !(d == 0 && a == 0)) nm[d][a] = wr_data[p*32 +: 32];
                end
                for (int j = 0; j < 3; j++) begin
                    a = int'(rd_addr[j*5 +: 5]);
                    if (rd_en[j]) e[d][j*32 +: 32] = a >= 24 ? 32'h0 : d == 0 ? nm[d][a] : m[d][a];
                end
                m[d] = nm[d];
            end
            tick();
            total += 2;
            if (rd_data_a !== e[0]) begin bad++; $display("FAIL soak_a cycle=%0d got=%h exp=%h", c, rd_data_a, e[0]); end
            if (rd_data_b !== e[1]) begin bad++; $display("FAIL soak_b cycle=%0d got=%h exp=%h", c, rd_data_b, e[1]); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_bypass();
        test_conflict();
        test_hold();
        test_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
